// File: rtl/spi_clock_engine.sv
// -----------------------------------------------------------------------------
// spi_clock_engine
// SPI master clock/shift engine. Derives a programmable-rate SCLK from aclk,
// supports all four CPOL/CPHA modes, MSB-first frames of DATA_WIDTH bits and
// one-of-NUM_CS active-low chip selects. One frame per valid/ready handshake.
//
// Ports
//   aclk      in   1            system clock
//   aresetn   in   1            asynchronous active-low reset
//   cpol      in   1            SCLK idle level (taken at accept)
//   cpha      in   1            0: sample leading edge, 1: sample trailing edge
//   clk_div   in   DIV_WIDTH    SCLK half-period minus one, in aclk cycles
//   cs_sel    in   CS_W         chip select index (out-of-range -> no CS)
//   tx_data   in   DATA_WIDTH   word to transmit
//   tx_valid  in   1            word available
//   tx_ready  out  1            engine idle, word accepted when tx_valid
//   rx_data   out  DATA_WIDTH   last received word
//   rx_valid  out  1            one-cycle pulse when rx_data updates
//   busy      out  1            engine not idle
//   sclk      out  1            SPI clock (registered)
//   mosi      out  1            SPI data out (registered)
//   miso      in   1            SPI data in, already synchronised
//   cs_n      out  NUM_CS       active-low chip selects (registered)
// -----------------------------------------------------------------------------
module spi_clock_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int NUM_CS     = 4,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    // Edge counter must hold 0..2*DATA_WIDTH.
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DIV_WIDTH-1:0]  div_cnt_r;
    logic [EW-1:0]         edge_cnt_r;
    logic                  cpha_r;
    logic [DIV_WIDTH-1:0]  clk_div_r;
    logic [DATA_WIDTH-1:0] tx_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;

    logic                  accept_s;
    logic                  wrap_s;
    logic [EW-1:0]         edge_num_s;
    logic                  lead_edge_s;
    logic                  last_edge_s;
    logic                  sample_s;

    // Active-low one-hot decode; an index beyond NUM_CS selects nothing.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] res;
        res = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) begin
                res[i] = 1'b0;
            end else begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    assign tx_ready = (state_r == ST_IDLE);
    assign busy     = (state_r != ST_IDLE);

    // Handshake, divider wrap, edge classification and next-state selection.
    always_comb begin
        accept_s    = tx_valid && (state_r == ST_IDLE);
        wrap_s      = (div_cnt_r == clk_div_r);
        edge_num_s  = edge_cnt_r + EW'(1);
        // Odd edge numbers move SCLK away from its idle level.
        lead_edge_s = edge_num_s[0];
        last_edge_s = (edge_num_s == EW'(2 * DATA_WIDTH));
        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
        sample_s    = lead_edge_s ^ cpha_r;
        state_s     = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_LEAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (wrap_s) begin
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_LEAD;
                end
            end
            ST_XFER: begin
                if (wrap_s && last_edge_s) begin
                    state_s = ST_TRAIL;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_TRAIL: begin
                if (wrap_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TRAIL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Half-period divider and SCLK edge counter; both restart on every phase change.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_cnt_r  <= '0;
            edge_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            div_cnt_r  <= '0;
            edge_cnt_r <= '0;
        end else if (wrap_s) begin
            div_cnt_r <= '0;
            if (state_r == ST_XFER) begin
                edge_cnt_r <= last_edge_s ? EW'(0) : edge_num_s;
            end
        end else begin
            div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
        end
    end

    // Frame configuration captured at accept and held for the whole frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cpha_r    <= 1'b0;
            clk_div_r <= '0;
        end else if (accept_s) begin
            cpha_r    <= cpha;
            clk_div_r <= clk_div;
        end
    end

    // SPI pins, shift registers and receive handoff.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_sh_r  <= '0;
            rx_sh_r  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // SCLK tracks the live idle level so the line is correct before CS falls.
                    sclk <= cpol;
                    if (accept_s) begin
                        cs_n    <= cs_decode(cs_sel);
                        rx_sh_r <= '0;
                        if (cpha) begin
                            mosi    <= 1'b0;
                            tx_sh_r <= tx_data;
                        end else begin
                            // CPHA=0 needs the MSB on the line before the first edge.
                            mosi    <= tx_data[DATA_WIDTH-1];
                            tx_sh_r <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        cs_n <= '1;
                        mosi <= 1'b0;
                    end
                end
                ST_LEAD: begin
                    sclk <= sclk;
                end
                ST_XFER: begin
                    if (wrap_s) begin
                        sclk <= ~sclk;
                        if (sample_s) begin
                            rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], miso};
                        end else if (!last_edge_s) begin
                            mosi    <= tx_sh_r[DATA_WIDTH-1];
                            tx_sh_r <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_TRAIL: begin
                    if (wrap_s) begin
                        cs_n     <= '1;
                        rx_data  <= rx_sh_r;
                        rx_valid <= 1'b1;
                    end
                end
                default: begin
                    cs_n <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_clock_engine.sv
module tb_spi_clock_engine;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] clk_div = 8'd0;
    logic [1:0] cs_sel = 2'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [3:0] cs_n;

    // second instance: NUM_CS=5 so an out-of-range index is expressible
    logic [2:0] cs_sel5 = 3'd5;
    logic       tx_valid5 = 1'b0;
    logic       tx_ready5;
    logic [7:0] rx_data5;
    logic       rx_valid5;
    logic       busy5;
    logic       sclk5;
    logic       mosi5;
    logic [4:0] cs_n5;

    logic       loopback = 1'b1;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] slv_sh = 8'h00;
    logic       miso_slv = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    assign miso = loopback ? mosi : miso_slv;

    always #5 aclk = ~aclk;

    spi_clock_engine #(.DATA_WIDTH(8), .DIV_WIDTH(8), .NUM_CS(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
        .cs_sel(cs_sel), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_clock_engine #(.DATA_WIDTH(8), .DIV_WIDTH(8), .NUM_CS(5)) dut5 (
        .aclk(aclk), .aresetn(aresetn), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
        .cs_sel(cs_sel5), .tx_data(tx_data), .tx_valid(tx_valid5), .tx_ready(tx_ready5),
        .rx_data(rx_data5), .rx_valid(rx_valid5), .busy(busy5), .sclk(sclk5), .mosi(mosi5),
        .miso(mosi5), .cs_n(cs_n5)
    );

    // Slave model on CS0: loads its word when selected, shifts out on the non-sampling edge.
    always @(negedge cs_n[0]) begin
        slv_sh = slave_word;
        if (!cpha) begin
            miso_slv = slv_sh[7];
            slv_sh   = {slv_sh[6:0], 1'b0};
        end
    end

    always @(sclk) begin
        if (cs_n[0] === 1'b0 && ((sclk ^ cpol) == cpha)) begin
            miso_slv = slv_sh[7];
            slv_sh   = {slv_sh[6:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame on the main instance with timing, edge, CS and data checks.
    task automatic frame(input logic pol, input logic pha, input logic [7:0] div,
                         input logic [1:0] sel, input logic [7:0] data,
                         input logic [7:0] exp_rx, input string tag);
        int n, edges, t1, t2, viol;
        logic prev_s, prev_m, done, lead;
        logic [3:0] cs_first, cs_exp;
        @(negedge aclk);
        cpol = pol; cpha = pha; clk_div = div; cs_sel = sel; tx_data = data;
        @(negedge aclk);
        @(negedge aclk);
        check({tag, " idle_sclk"}, sclk, pol);
        check({tag, " ready"}, tx_ready, 1'b1);
        tx_valid = 1'b1;
        n = 0; edges = 0; t1 = 0; t2 = 0; viol = 0; done = 1'b0;
        prev_s = sclk; prev_m = mosi; cs_first = 4'hF;
        while (!done && n < 6000) begin
            @(negedge aclk);
            n++;
            if (n == 1) begin
                tx_valid = 1'b0;
                cs_first = cs_n;
            end
            if (sclk !== prev_s) begin
                edges++;
                if (edges == 1) t1 = n;
                if (edges == 2) t2 = n;
                lead = (sclk !== pol);
                if ((lead != pha) && (mosi !== prev_m)) viol++;
            end
            prev_s = sclk;
            prev_m = mosi;
            if (rx_valid === 1'b1) done = 1'b1;
        end
        cs_exp = 4'hF;
        cs_exp[sel] = 1'b0;
        check({tag, " frame_len"}, 64'(n), 64'(1 + 18 * (int'(div) + 1)));
        check({tag, " edges"}, 64'(edges), 64'd16);
        check({tag, " half_period"}, 64'(t2 - t1), 64'(int'(div) + 1));
        check({tag, " mosi_stable"}, 64'(viol), 64'd0);
        check({tag, " cs_first"}, cs_first, cs_exp);
        check({tag, " rx_data"}, rx_data, exp_rx);
        check({tag, " cs_end"}, cs_n, 4'hF);
        check({tag, " sclk_end"}, sclk, pol);
        check({tag, " busy_end"}, busy, 1'b0);
        @(negedge aclk);
        check({tag, " rx_pulse_1cyc"}, rx_valid, 1'b0);
    endtask

    initial begin
        int n, edges, gap, pulses, bad, rx1_c, rx_cnt;
        logic prev_s, in_gap;
        logic [7:0] rx_first, rx_second;

        // reset state
        @(negedge aclk);
        check("rst sclk", sclk, 1'b0);
        check("rst mosi", mosi, 1'b0);
        check("rst cs_n", cs_n, 4'hF);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst rx_data", rx_data, 8'h00);
        check("rst busy", busy, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;

        // mode 0 loopback
        loopback = 1'b1;
        frame(1'b0, 1'b0, 8'd1, 2'd0, 8'hA5, 8'hA5, "m0_loop");

        // all four modes against the slave model
        loopback = 1'b0;
        slave_word = 8'hC3;
        for (int m = 0; m < 4; m++) begin
            logic [1:0] mb;
            mb = 2'(m);
            frame(mb[1], mb[0], 8'd1, 2'd0, 8'h3C, 8'hC3, $sformatf("mode%0d", m));
        end

        // divider extremes
        loopback = 1'b1;
        frame(1'b0, 1'b0, 8'd0, 2'd1, 8'h5A, 8'h5A, "div0");
        frame(1'b1, 1'b1, 8'd255, 2'd1, 8'hE7, 8'hE7, "div255");

        // back-to-back with tx_valid held, cs_sel 2
        @(negedge aclk);
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; cs_sel = 2'd2;
        tx_data = 8'h11; tx_valid = 1'b1;
        rx_cnt = 0; rx1_c = 0; gap = 0; bad = 0; in_gap = 1'b0;
        rx_first = 8'h00; rx_second = 8'h00;
        for (int c = 1; c <= 90; c++) begin
            @(negedge aclk);
            if (c == 1) tx_data = 8'h22;
            if (rx_cnt == 1 && c == rx1_c + 1) tx_valid = 1'b0;
            if (cs_n !== 4'b1011 && cs_n !== 4'b1111) bad++;
            if (in_gap) begin
                if (cs_n === 4'b1111) gap++;
                else in_gap = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                rx_cnt++;
                if (rx_cnt == 1) begin
                    rx1_c = c; rx_first = rx_data; in_gap = 1'b1;
                    if (cs_n === 4'b1111) gap++;
                end else if (rx_cnt == 2) begin
                    rx_second = rx_data;
                    check("b2b second_rx_cycle", 64'(c), 64'd74);
                end
            end
        end
        tx_valid = 1'b0;
        check("b2b rx_count", 64'(rx_cnt), 64'd2);
        check("b2b first_rx_cycle", 64'(rx1_c), 64'd37);
        check("b2b rx_first", rx_first, 8'h11);
        check("b2b rx_second", rx_second, 8'h22);
        check("b2b cs_values", 64'(bad), 64'd0);
        check("b2b cs_gap", 64'(gap >= 1), 64'd1);

        // reset during edge 5
        @(negedge aclk);
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; cs_sel = 2'd0; tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(negedge aclk);
        tx_valid = 1'b0;
        edges = 0; n = 0; prev_s = sclk;
        while (edges < 5 && n < 100) begin
            @(negedge aclk);
            n++;
            if (sclk !== prev_s) edges++;
            prev_s = sclk;
        end
        check("rst_mid edge5", 64'(edges), 64'd5);
        aresetn = 1'b0;
        #1;
        check("rst_mid cs_n", cs_n, 4'hF);
        check("rst_mid sclk", sclk, 1'b0);
        check("rst_mid busy", busy, 1'b0);
        @(negedge aclk);
        check("rst_mid rx_valid", rx_valid, 1'b0);
        aresetn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge aclk);
            if (rx_valid === 1'b1) pulses++;
        end
        check("rst_mid no_rx", 64'(pulses), 64'd0);
        frame(1'b0, 1'b0, 8'd1, 2'd3, 8'h96, 8'h96, "after_rst");

        // out-of-range chip select on the NUM_CS=5 instance
        @(negedge aclk);
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; tx_data = 8'h3C; cs_sel5 = 3'd5;
        tx_valid5 = 1'b1;
        edges = 0; bad = 0; pulses = 0; n = 0; prev_s = sclk5; rx1_c = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge aclk);
            if (c == 1) tx_valid5 = 1'b0;
            if (cs_n5 !== 5'h1F) bad++;
            if (sclk5 !== prev_s) edges++;
            prev_s = sclk5;
            if (rx_valid5 === 1'b1) begin
                pulses++;
                rx1_c = c;
            end
        end
        check("cs_oor cs_n", 64'(bad), 64'd0);
        check("cs_oor edges", 64'(edges), 64'd16);
        check("cs_oor pulses", 64'(pulses), 64'd1);
        check("cs_oor rx_cycle", 64'(rx1_c), 64'd37);
        check("cs_oor rx_data", rx_data5, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
